// File: rtl/sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog
//   Parameterised single-clock FIFO used as a rate-matching buffer between a
//   producer and a consumer in the same clock domain. Provides runtime
//   programmable almost-full / almost-empty thresholds, a synchronous flush,
//   one-cycle error pulses with sticky copies, and an optional
//   first-word-fall-through read mode selected by the FWFT_EN macro.
//
//   Compile-time option:
//     FWFT_EN  defined   : data_out shows the head word whenever !empty,
//                          valid = !empty, rd_en pops the shown word.
//              undefined : registered read, data_out/valid update one cycle
//                          after an accepted rd_en.
//
//   Ports:
//     clk, rst            rising-edge clock, asynchronous active-high reset
//     wr_en, data_in      write request and data
//     rd_en               read (pop) request
//     data_out, valid     read data and its qualifier
//     flush               synchronous empty request (highest priority after rst)
//     thr_wr              load ae_thr_in / af_thr_in into the threshold registers
//     ae_thr_in,af_thr_in new almost-empty / almost-full thresholds
//     err_clr             clear sticky error flags
//     count               stored words, 0..DEPTH
//     empty, almost_empty, full, almost_full   level flags from count
//     overflow, underflow one-cycle pulses for rejected write / read
//     ovf_sticky, unf_sticky  latched error flags
//
//   Handshake: a write is taken on a rising edge when wr_en is high and the
//   FIFO has room (not full, or a read is taken on the same edge). A read is
//   taken when rd_en is high and the FIFO is not empty. Requests that cannot
//   be taken are dropped and reported through overflow/underflow; there is
//   no back-pressure other than the full/empty flags.
// -----------------------------------------------------------------------------
module sync_fifo_prog #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int AE_RESET   = 2,
   parameter int AF_RESET   = 30
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic                  flush,
   input  logic                  thr_wr,
   input  logic [ADDR_WIDTH:0]   ae_thr_in,
   input  logic [ADDR_WIDTH:0]   af_thr_in,
   input  logic                  err_clr,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  empty,
   output logic                  almost_empty,
   output logic                  full,
   output logic                  almost_full,
   output logic                  valid,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  ovf_sticky,
   output logic                  unf_sticky
);

   localparam int CW    = ADDR_WIDTH + 1;
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = CW'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count_q;
   logic [ADDR_WIDTH:0]   ae_thr;
   logic [ADDR_WIDTH:0]   af_thr;
   logic                  rd_accept;
   logic                  wr_accept;
   logic                  ovf_evt;
   logic                  unf_evt;
   logic                  overflow_q;
   logic                  underflow_q;
   logic                  ovf_sticky_q;
   logic                  unf_sticky_q;

   // Flags come straight from the registered count and thresholds.
   assign empty        = (count_q == '0);
   assign full         = (count_q == DEPTH_CNT);
   assign almost_empty = (count_q <= ae_thr);
   assign almost_full  = (count_q >= af_thr);
   assign count        = count_q;

   // A write into a full FIFO is still taken when a read frees a slot on the
   // same edge; the new word lands in the slot being vacated.
   assign rd_accept = rd_en && !empty;
   assign wr_accept = wr_en && (!full || rd_accept);

   // Flush swallows any request in its cycle, so it never reports an error.
   assign ovf_evt = !flush && wr_en && !wr_accept;
   assign unf_evt = !flush && rd_en && !rd_accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
         ovf_sticky_q <= 1'b0;
         unf_sticky_q <= 1'b0;
         ae_thr       <= CW'(AE_RESET);
         af_thr       <= CW'(AF_RESET);
      end else begin
         if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
         end else begin
            if (wr_accept) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (rd_accept) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            if (wr_accept && !rd_accept)
               count_q <= count_q + CW'(1);
            else if (rd_accept && !wr_accept)
               count_q <= count_q - CW'(1);
         end

         overflow_q  <= ovf_evt;
         underflow_q <= unf_evt;

         // A new error wins over a clear issued in the same cycle.
         if (ovf_evt)      ovf_sticky_q <= 1'b1;
         else if (err_clr) ovf_sticky_q <= 1'b0;
         if (unf_evt)      unf_sticky_q <= 1'b1;
         else if (err_clr) unf_sticky_q <= 1'b0;

         if (thr_wr) begin
            ae_thr <= ae_thr_in;
            af_thr <= af_thr_in;
         end
      end
   end

   // Storage has no reset; contents are meaningless once the pointers clear.
   always_ff @(posedge clk) begin
      if (wr_accept && !flush)
         mem[wr_ptr] <= data_in;
   end

   assign overflow   = overflow_q;
   assign underflow  = underflow_q;
   assign ovf_sticky = ovf_sticky_q;
   assign unf_sticky = unf_sticky_q;

`ifdef FWFT_EN
   // hold_q tracks the word on display so data_out keeps its last value once
   // the FIFO runs empty (including after a flush).
   logic [DATA_WIDTH-1:0] hold_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         hold_q <= '0;
      else if (!empty)
         hold_q <= mem[rd_ptr];
   end

   assign data_out = empty ? hold_q : mem[rd_ptr];
   assign valid    = !empty;
`else
   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= rd_accept;
         if (rd_accept)
            data_q <= mem[rd_ptr];
      end
   end

   assign data_out = data_q;
   assign valid    = valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_prog
//   Self-checking bench for sync_fifo_prog (default parameters, 8 x 32).
//   A directed vector table, hand-written corner sequences and a randomized
//   run, all checked against a queue-based reference model of the FIFO.
// -----------------------------------------------------------------------------
module tb_sync_fifo_prog;

   localparam int DW    = 8;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] data_out;
   logic          flush = 1'b0;
   logic          thr_wr = 1'b0;
   logic [AW:0]   ae_thr_in = '0;
   logic [AW:0]   af_thr_in = '0;
   logic          err_clr = 1'b0;
   logic [AW:0]   count;
   logic          empty, almost_empty, full, almost_full, valid;
   logic          overflow, underflow, ovf_sticky, unf_sticky;

   sync_fifo_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AE_RESET(2), .AF_RESET(30)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(data_out), .flush(flush), .thr_wr(thr_wr), .ae_thr_in(ae_thr_in),
      .af_thr_in(af_thr_in), .err_clr(err_clr), .count(count), .empty(empty),
      .almost_empty(almost_empty), .full(full), .almost_full(almost_full),
      .valid(valid), .overflow(overflow), .underflow(underflow),
      .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard / reference model ----------------
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [DW-1:0] exp_q[$];
   int            m_ae, m_af;
   logic [DW-1:0] m_data, m_last;
   logic          m_valid, m_ovf, m_unf, m_os, m_us;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_ae = 2; m_af = 30;
      m_data = '0; m_last = '0;
      m_valid = 0; m_ovf = 0; m_unf = 0; m_os = 0; m_us = 0;
   endtask

   // One clock edge of the FIFO described in terms of a word queue.
   task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic r,
                             input logic f, input logic t, input logic [AW:0] a,
                             input logic [AW:0] af_v, input logic c);
      logic rd_ok, wr_ok;
      if (f) begin
         exp_q.delete();
         m_valid = 0; m_ovf = 0; m_unf = 0;
      end else begin
         rd_ok = r && (exp_q.size() > 0);
         wr_ok = w && ((exp_q.size() < DEPTH) || rd_ok);
`ifdef FWFT_EN
         if (rd_ok) void'(exp_q.pop_front());
`else
         if (rd_ok) m_data = exp_q.pop_front();
         m_valid = rd_ok;
`endif
         if (wr_ok) exp_q.push_back(d);
         m_ovf = w && !wr_ok;
         m_unf = r && !rd_ok;
      end
      if (m_ovf) m_os = 1; else if (c) m_os = 0;
      if (m_unf) m_us = 1; else if (c) m_us = 0;
      if (t) begin m_ae = int'(a); m_af = int'(af_v); end
`ifdef FWFT_EN
      if (exp_q.size() > 0) begin m_data = exp_q[0]; m_last = exp_q[0]; end
      else m_data = m_last;
      m_valid = (exp_q.size() > 0);
`endif
   endtask

   task automatic compare_model();
      int n;
      n = exp_q.size();
      chk("count",        32'(count),        32'(n));
      chk("empty",        32'(empty),        32'(n == 0));
      chk("full",         32'(full),         32'(n == DEPTH));
      chk("almost_empty", 32'(almost_empty), 32'(n <= m_ae));
      chk("almost_full",  32'(almost_full),  32'(n >= m_af));
      chk("valid",        32'(valid),        32'(m_valid));
      chk("data_out",     32'(data_out),     32'(m_data));
      chk("overflow",     32'(overflow),     32'(m_ovf));
      chk("underflow",    32'(underflow),    32'(m_unf));
      chk("ovf_sticky",   32'(ovf_sticky),   32'(m_os));
      chk("unf_sticky",   32'(unf_sticky),   32'(m_us));
   endtask

   // ---------------- driver ----------------
   // Called at a falling edge; returns at the next falling edge with outputs
   // already checked against the model.
   task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic f = 0, input logic t = 0, input logic [AW:0] a = 0,
                       input logic [AW:0] af_v = 0, input logic c = 0);
      wr_en = w; data_in = d; rd_en = r; flush = f;
      thr_wr = t; ae_thr_in = a; af_thr_in = af_v; err_clr = c;
      @(posedge clk);
      model_edge(w, d, r, f, t, a, af_v, c);
      #1;
      compare_model();
      @(negedge clk);
      wr_en = 0; rd_en = 0; flush = 0; thr_wr = 0; err_clr = 0;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      chk({tag, "_count"},  32'(count),        32'd0);
      chk({tag, "_empty"},  32'(empty),        32'd1);
      chk({tag, "_aempty"}, 32'(almost_empty), 32'd1);
      chk({tag, "_full"},   32'(full),         32'd0);
      chk({tag, "_afull"},  32'(almost_full),  32'd0);
      chk({tag, "_valid"},  32'(valid),        32'd0);
      chk({tag, "_data"},   32'(data_out),     32'd0);
      chk({tag, "_errs"},   32'({overflow, underflow, ovf_sticky, unf_sticky}), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          wr;
      logic [DW-1:0] din;
      logic          rd;
      logic          fl;
      logic          thr;
      logic [AW:0]   ae;
      logic [AW:0]   af;
      logic          clr;
      int            e_count;
      logic          e_ovf, e_unf, e_os, e_us, e_ae, e_af;
   } vec_t;

   vec_t vecs[12];

   initial begin
      // Starting from reset: empty, ae_thr=2, af_thr=30.
      vecs[0]  = '{0, 8'h00, 1, 0, 0, 6'd0,  6'd0,  0, 0, 0, 1, 0, 1, 1, 0}; // read on empty
      vecs[1]  = '{0, 8'h00, 0, 0, 0, 6'd0,  6'd0,  1, 0, 0, 0, 0, 0, 1, 0}; // err_clr
      vecs[2]  = '{1, 8'hA1, 1, 0, 0, 6'd0,  6'd0,  0, 1, 0, 1, 0, 1, 1, 0}; // wr+rd on empty
      vecs[3]  = '{1, 8'hA2, 0, 0, 0, 6'd0,  6'd0,  0, 2, 0, 0, 0, 1, 1, 0};
      vecs[4]  = '{1, 8'hA3, 0, 0, 0, 6'd0,  6'd0,  0, 3, 0, 0, 0, 1, 0, 0};
      vecs[5]  = '{0, 8'h00, 0, 0, 1, 6'd3,  6'd3,  0, 3, 0, 0, 0, 1, 1, 1}; // thresholds 3/3
      vecs[6]  = '{0, 8'h00, 1, 0, 0, 6'd0,  6'd0,  1, 2, 0, 0, 0, 0, 1, 0}; // pop + clear
      vecs[7]  = '{1, 8'hEE, 1, 1, 0, 6'd0,  6'd0,  0, 0, 0, 0, 0, 0, 1, 0}; // flush wins
      vecs[8]  = '{0, 8'h00, 0, 0, 1, 6'd0,  6'd0,  0, 0, 0, 0, 0, 0, 1, 1}; // af_thr=0
      vecs[9]  = '{1, 8'hB0, 0, 0, 0, 6'd0,  6'd0,  0, 1, 0, 0, 0, 0, 0, 1};
      vecs[10] = '{0, 8'h00, 0, 0, 1, 6'd32, 6'd31, 0, 1, 0, 0, 0, 0, 1, 0}; // ae_thr=DEPTH
      vecs[11] = '{0, 8'h00, 1, 0, 0, 6'd0,  6'd0,  0, 0, 0, 0, 0, 0, 1, 0};
   end

   // ---------------- test sequence ----------------
   initial begin
      model_reset();
      @(negedge clk);
      do_reset("rst0");

      // Table-driven vectors
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].fl,
              vecs[i].thr, vecs[i].ae, vecs[i].af, vecs[i].clr);
         chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
         chk($sformatf("vec%0d_ovf", i),   32'(overflow), 32'(vecs[i].e_ovf));
         chk($sformatf("vec%0d_unf", i),   32'(underflow), 32'(vecs[i].e_unf));
         chk($sformatf("vec%0d_os", i),    32'(ovf_sticky), 32'(vecs[i].e_os));
         chk($sformatf("vec%0d_us", i),    32'(unf_sticky), 32'(vecs[i].e_us));
         chk($sformatf("vec%0d_ae", i),    32'(almost_empty), 32'(vecs[i].e_ae));
         chk($sformatf("vec%0d_af", i),    32'(almost_full), 32'(vecs[i].e_af));
      end

      do_reset("rst1");

      // Fill 0x00..0x1F
      for (int i = 0; i < DEPTH; i++) step(1, DW'(i), 0);
      chk("fill_count", 32'(count), 32'd32);
      chk("fill_full",  32'(full), 32'd1);
      chk("fill_afull", 32'(almost_full), 32'd1);

      // Overflow while full
      step(1, 8'hFF, 0);
      chk("ovf_pulse",  32'(overflow), 32'd1);
      chk("ovf_sticky", 32'(ovf_sticky), 32'd1);
      chk("ovf_count",  32'(count), 32'd32);
      step(0, 0, 0);
      chk("ovf_one_cycle", 32'(overflow), 32'd0);

      // Full: simultaneous write and read keeps count, pops the oldest
      step(1, 8'hAA, 1);
      chk("full_wrrd_count", 32'(count), 32'd32);
`ifndef FWFT_EN
      chk("full_wrrd_data",  32'(data_out), 32'h00);
      chk("full_wrrd_valid", 32'(valid), 32'd1);
`endif

      // Drain everything (model checks every popped word)
      for (int i = 0; i < DEPTH; i++) step(0, 0, 1);
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_count", 32'(count), 32'd0);
`ifndef FWFT_EN
      chk("drain_last", 32'(data_out), 32'hAA);
`endif
      step(0, 0, 0, 0, 0, 0, 0, 1);
      chk("clr_sticky", 32'(ovf_sticky), 32'd0);

      // Empty: simultaneous write and read
      step(1, 8'h55, 1);
      chk("empty_wrrd_unf",   32'(underflow), 32'd1);
      chk("empty_wrrd_count", 32'(count), 32'd1);
      step(0, 0, 1);
`ifndef FWFT_EN
      chk("empty_wrrd_pop", 32'(data_out), 32'h55);
`endif

      // Programmable thresholds
      step(0, 0, 0, 0, 1, 6'd4, 6'd8, 1);
      for (int i = 1; i <= 8; i++) begin
         step(1, DW'(8'h10 + i), 0);
         chk($sformatf("thr_af_at%0d", i), 32'(almost_full), 32'(i >= 8));
      end
      for (int i = 7; i >= 0; i--) begin
         step(0, 0, 1);
         chk($sformatf("thr_ae_at%0d", i), 32'(almost_empty), 32'(i <= 4));
      end

      // Flush after pointer wrap
      for (int i = 0; i < 20; i++) step(1, DW'(8'h40 + i), 0);
      for (int i = 0; i < 15; i++) step(0, 0, 1);
      for (int i = 0; i < 20; i++) step(1, DW'(8'h80 + i), 0);
      chk("wrap_count", 32'(count), 32'd25);
      step(1, 8'h99, 1, 1);
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_empty", 32'(empty), 32'd1);
      chk("flush_noovf", 32'(overflow), 32'd0);
      step(1, 8'h3C, 0);
      step(0, 0, 1);
`ifndef FWFT_EN
      chk("flush_pop", 32'(data_out), 32'h3C);
`endif

`ifdef FWFT_EN
      step(1, 8'hB6, 0);
      chk("fwft_data",  32'(data_out), 32'hB6);
      chk("fwft_valid", 32'(valid), 32'd1);
      step(0, 0, 1);
      chk("fwft_pop_valid", 32'(valid), 32'd0);
      chk("fwft_pop_empty", 32'(empty), 32'd1);
`endif

      // Reset in the middle of operation
      for (int i = 0; i < 6; i++) step(1, DW'($urandom), 0);
      do_reset("rst_mid");

      // Randomized traffic with occasional flush / threshold / clear
      for (int i = 0; i < 3000; i++) begin
         int wp, rp;
         wp = ((i / 400) % 2 == 0) ? 70 : 35;
         rp = 100 - wp;
         step($urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) < rp,
              $urandom_range(0, 59) == 0, $urandom_range(0, 49) == 0,
              (AW+1)'($urandom_range(0, 40)), (AW+1)'($urandom_range(0, 40)),
              $urandom_range(0, 29) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
- Parameterised single-clock FIFO; next-generation replacement for the fixed 8x32 synchronous FIFO.
- Adds the following over that FIFO:
  - generic width and depth;
  - runtime-programmable almost-full/almost-empty thresholds;
  - synchronous flush;
  - sticky error flags with clear;
  - compile-time first-word-fall-through (FWFT) read mode.
- Sits between a producer and consumer in the same clock domain. Used as a rate-matching buffer.

Parameters:
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 5: pointer width. DEPTH = 2**ADDR_WIDTH (default 32).
- AE_RESET, 2: reset value of the internal almost-empty threshold register.
- AF_RESET, 30: reset value of the internal almost-full threshold register.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- rd_en  in  1  read request (pop)
- data_out  out  DATA_WIDTH  read data
- flush  in  1  synchronous empty request
- thr_wr  in  1  load ae_thr_in/af_thr_in into the threshold registers
- ae_thr_in  in  ADDR_WIDTH+1  new almost-empty threshold
- af_thr_in  in  ADDR_WIDTH+1  new almost-full threshold
- err_clr  in  1  clear sticky error flags
- count  out  ADDR_WIDTH+1  words stored, 0..DEPTH
- empty  out  1  count==0
- almost_empty  out  1  count<=ae_thr
- full  out  1  count==DEPTH
- almost_full  out  1  count>=af_thr
- valid  out  1  data_out holds a freshly popped word
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected
- ovf_sticky  out  1  latched overflow
- unf_sticky  out  1  latched underflow

Behaviour:
- Reset (rst=1, asynchronous) forces:
  - pointers and count = 0; data_out = 0;
  - valid, overflow, underflow, ovf_sticky, unf_sticky = 0;
  - ae_thr = AE_RESET, af_thr = AF_RESET.
  - Resulting flags: empty=1, almost_empty=1, full=0, almost_full=0.
  - Reset mid-operation discards all contents; memory array is not cleared.
- Accept rules, evaluated per rising edge:
  - Write is accepted if wr_en && (!full || rd_accept).
  - Read is accepted if rd_en && !empty.
  - Pointers wrap modulo DEPTH.
  - count changes +1 on write only, -1 on read only, and is unchanged on both or neither.
- Full with wr_en=1 and rd_en=1: both accepted, count stays at DEPTH. The new word occupies the freed slot.
- Empty with wr_en=1 and rd_en=1: write accepted, read rejected, underflow pulses. count becomes 1.
- Standard read (FWFT_EN undefined):
  - Accepted read loads the head word into data_out at that edge. valid=1 for exactly the following cycle.
  - Rejected or absent read: data_out holds its value, valid=0.
  - Read latency is 1 cycle.
- Error pulses:
  - overflow=1 for one cycle after an edge where wr_en=1 and the write was rejected.
  - underflow=1 for one cycle after an edge where rd_en=1 and the read was rejected.
  - Each pulse also sets its sticky flag.
  - Sticky flags clear only via err_clr or rst. Set takes priority over err_clr in the same cycle.
- Flags:
  - All flags are derived from registered count and the threshold registers. No extra latency beyond count.
  - Thresholds compare unsigned at ADDR_WIDTH+1 bits.
  - af_thr=0 gives almost_full always 1. ae_thr>=DEPTH gives almost_empty always 1.
- thr_wr loads both threshold registers at the edge. The new values are used from the next cycle.
- flush:
  - Highest priority after rst. At the edge: pointers and count = 0, valid=0.
  - wr_en/rd_en in the same cycle are ignored and generate no error pulses.
  - data_out, thresholds and sticky flags are retained.

Optional Feature:
- Macro name: FWFT_EN.
- Defined:
  - data_out continuously presents the head word whenever !empty. valid = !empty, combinational from count.
  - rd_en acknowledges and pops the head word. The next word appears on the following cycle.
  - On empty, data_out holds its last value and valid=0.
  - Write-to-data_out latency is 1 cycle after the write edge into an empty FIFO.
- Undefined: standard registered read as described above.
- Accept rules, flags and error behaviour are identical in both modes.

Test Plan:
- Fill/drain: write 0x00..0x1F with no reads -> count=32, full=1, almost_full=1. Then 32 reads -> data_out sequence 0x00..0x1F, each with valid=1 the following cycle. Ends with empty=1, count=0.
- Overflow: when full, write 0xFF -> overflow pulses 1 cycle, ovf_sticky=1, count stays 32. Next pop returns 0x00, not 0xFF. err_clr -> ovf_sticky=0.
- Simultaneous access: when full, wr 0xAA plus rd -> count stays 32, the popped word is the oldest. When empty, wr 0x55 plus rd -> underflow=1, count=1, the next pop returns 0x55.
- Thresholds: thr_wr with ae=4, af=8. Write 8 words -> almost_full asserts on the cycle count reaches 8. Read down -> almost_empty asserts on the cycle count reaches 4.
- Flush and wrap: write 20, read 15, write 20 (pointer wrap), flush -> count=0, empty=1, no overflow. Write 0x3C, read -> 0x3C.
- FWFT_EN defined: write 0xB6 into an empty FIFO -> next cycle data_out=0xB6 and valid=1 with no rd_en. Pop -> valid=0, empty=1.
